// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// master: the controlling FSM. It drives load/load_val/start/en/auto_reload and observes status.
// slave : the timer. It drives q/zero/tc_pulse/busy/done.
//   load        parallel-load strobe for load_val
//   load_val    value copied into the counter and the reload register
//   start       begin counting (from IDLE or DONE)
//   en          count enable; the count holds when low
//   auto_reload 1 = periodic, 0 = one-shot
//   q           current count, registered
//   zero        combinational (q == 0)
//   tc_pulse    registered one-cycle terminal-count strobe
//   busy        timer is in RUN
//   done        timer is in DONE
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc_pulse;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, en, auto_reload,
    input  q, zero, tc_pulse, busy, done
  );

  modport slave (
    input  load, load_val, start, en, auto_reload,
    output q, zero, tc_pulse, busy, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Programmable synchronous down-counter/timer with one-shot and auto-reload modes.
// A value is loaded and then counted down once per enabled clock. A one-cycle tc_pulse
// marks terminal count.
//   clk   system clock; all state changes on posedge
//   reset asynchronous, active-high; clears all state
//   bus   down_counter_timer_if slave modport (controls in, count/status out)
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  down_counter_timer_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      // load overrides start and counting in the same cycle
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          // starting from zero would tick immediately, so it is refused
          if (bus.start && (count_q != '0)) state_d = StRun;
        end
        StRun: begin
          if (bus.en) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (bus.auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = StDone;
              end
            end else if (count_q != '0) begin
              // guard keeps the count from wrapping below zero
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        StDone: begin
          if (bus.start && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.q        = count_q;
  assign bus.zero     = (count_q == '0);
  assign bus.tc_pulse = tc_q;
  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;
  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic reset;

  down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the timer's phase plus the count and the reload value.
  typedef enum int {MIdle, MRun, MDone} phase_t;
  phase_t           m_ph;
  int               m_q;
  int               m_reload;
  bit               m_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = MIdle; m_q = 0; m_reload = 0; m_tc = 1'b0;
  endfunction

  // One clock edge according to the behavioural rules.
  function automatic void model_step();
    m_tc = 1'b0;
    if (bus.load) begin
      m_q = int'(bus.load_val);
      m_reload = m_q;
      m_ph = MIdle;
    end else if (m_ph == MIdle) begin
      if (bus.start && m_q > 0) m_ph = MRun;
    end else if (m_ph == MRun) begin
      if (bus.en) begin
        if (m_q == 1) begin
          m_tc = 1'b1;
          if (bus.auto_reload) m_q = m_reload;
          else begin
            m_q = 0;
            m_ph = MDone;
          end
        end else begin
          m_q = (m_q > 0) ? m_q - 1 : 0;
        end
      end
    end else begin
      if (bus.start && m_reload > 0) begin
        m_q = m_reload;
        m_ph = MRun;
      end
    end
  endfunction

  task automatic check_all();
    check("q",        32'(bus.q),    32'(m_q));
    check("zero",     32'(bus.zero), 32'(m_q == 0));
    check("tc_pulse", 32'(bus.tc_pulse), 32'(m_tc));
    check("busy",     32'(bus.busy), 32'(m_ph == MRun));
    check("done",     32'(bus.done), 32'(m_ph == MDone));
  endtask

  task automatic drive(input bit ld, input int lv, input bit st, input bit e, input bit ar);
    bus.load        = ld;
    bus.load_val    = WIDTH'(lv);
    bus.start       = st;
    bus.en          = e;
    bus.auto_reload = ar;
  endtask

  // Inputs change at negedge; the edge is modelled at posedge; outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges; called at a negedge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check({tag, "_q"},    32'(bus.q),        32'd0);
    check({tag, "_busy"}, 32'(bus.busy),     32'd0);
    check({tag, "_zero"}, 32'(bus.zero),     32'd1);
    check({tag, "_tc"},   32'(bus.tc_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp2[6];
    int exp3[9];
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // 1: reset asserted mid-RUN with q = 5
    drive(1, 5, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    check("t1_run_q", 32'(bus.q), 32'd5);
    async_reset("t1_rst");

    // 2: one-shot from 4
    exp2 = '{3, 2, 1, 0, 0, 0};
    drive(1, 4, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick();
    check("t2_start_q", 32'(bus.q), 32'd4);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_seq_q", 32'(bus.q), 32'(exp2[i]));
      check("t2_seq_tc", 32'(bus.tc_pulse), 32'(i == 3));
    end
    check("t2_done", 32'(bus.done), 32'd1);

    // 3: auto-reload period 3
    exp3 = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    drive(1, 3, 0, 1, 1); tick();
    drive(0, 0, 1, 1, 1); tick();
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t3_seq_q", 32'(bus.q), 32'(exp3[i]));
      check("t3_seq_tc", 32'(bus.tc_pulse), 32'(exp3[i] == 3));
      check("t3_busy", 32'(bus.busy), 32'd1);
    end

    // 4: en low holds the count
    drive(1, 6, 0, 1, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_q", 32'(bus.q), 32'd6);
    end
    drive(0, 0, 0, 1, 0);
    tick(); check("t4_resume_q", 32'(bus.q), 32'd5);
    tick(); check("t4_resume_q", 32'(bus.q), 32'd4);

    // 5: load wins over start
    drive(1, 9, 1, 1, 0); tick();
    check("t5_q", 32'(bus.q), 32'd9);
    check("t5_busy", 32'(bus.busy), 32'd0);
    drive(0, 0, 1, 1, 0); tick();
    check("t5_run", 32'(bus.busy), 32'd1);

    // 6a: start with zero loaded stays idle
    drive(1, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick(); tick();
    check("t6a_busy", 32'(bus.busy), 32'd0);
    check("t6a_tc", 32'(bus.tc_pulse), 32'd0);

    // 6b: restart from DONE reloads 7
    drive(1, 7, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    check("t6b_done", 32'(bus.done), 32'd1);
    drive(0, 0, 1, 1, 0); tick();
    check("t6b_q", 32'(bus.q), 32'd7);
    check("t6b_busy", 32'(bus.busy), 32'd1);

    // 6c: full-scale count, no wrap
    drive(1, 15, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      tick();
      check("t6c_q", 32'(bus.q), 32'((i < 15) ? 14 - i : 0));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 12) == 0, int'($urandom_range(0, 15)), ($urandom % 4) == 0,
            ($urandom % 5) != 0, ($urandom % 2) == 1);
      if (($urandom % 250) == 0) async_reset("rnd_rst");
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
